// File: rtl/uart_port_ctrl_pkg.sv
// Shared types and constants for the UART port controller.
package uart_port_ctrl_pkg;

  typedef enum logic [1:0] {
    M_BOOT   = 2'd0,
    M_RUN    = 2'd1,
    M_CPURST = 2'd2
  } mode_t;

  localparam logic [7:0] ASCII_ESC = 8'h1B;

endpackage

// File: rtl/uart_port_ctrl_arb.sv
// 2:1 round-robin stream arbiter with a single output register and
// per-input request enables.
module stream_arb2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_valid,
  input  logic              in0_en,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_valid,
  input  logic              in1_en,
  output logic              in1_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  // prio_q = 0: input 0 wins a tie; flips to the loser after each grant
  logic              prio_q, prio_d;
  logic              load_ok, req0, req1, grant0, grant1;

  always_comb begin
    load_ok = clk_en & (~valid_q | out_ready);
    req0    = in0_valid & in0_en;
    req1    = in1_valid & in1_en;
    grant0  = req0 & (~req1 | ~prio_q);
    grant1  = req1 & ~grant0;

    in0_ready = load_ok & grant0;
    in1_ready = load_ok & grant1;

    data_d  = data_q;
    valid_d = valid_q;
    prio_d  = prio_q;
    if (load_ok) begin
      if (grant0) begin
        data_d  = in0_data;
        valid_d = 1'b1;
        prio_d  = 1'b1;
      end else if (grant1) begin
        data_d  = in1_data;
        valid_d = 1'b1;
        prio_d  = 1'b0;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      prio_q  <= prio_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/uart_port_ctrl.sv
// BOOT/RUN mode controller: steers UART RX to BIOS or CPU, merges both TX
// streams, and sequences CPU reset on BIOS request.
module uart_port_ctrl
  import uart_port_ctrl_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] ESC_CHAR   = DATA_W'(ASCII_ESC),
  parameter int                ESC_COUNT  = 3,
  parameter int                RST_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] bios_rx_data,
  output logic              bios_rx_valid,
  input  logic              bios_rx_ready,
  input  logic [DATA_W-1:0] bios_tx_data,
  input  logic              bios_tx_valid,
  output logic              bios_tx_ready,
  output logic [DATA_W-1:0] cpu_rx_data,
  output logic              cpu_rx_valid,
  input  logic              cpu_rx_ready,
  input  logic [DATA_W-1:0] cpu_tx_data,
  input  logic              cpu_tx_valid,
  output logic              cpu_tx_ready,
  input  logic              boot_req,
  input  logic              rst_req,
  output logic [1:0]        mode,
  output logic              cpu_run,
  output logic              cpu_rst
);

  localparam int ESC_W = $clog2(ESC_COUNT + 1);
  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam logic [ESC_W-1:0] ESC_LAST = ESC_W'(ESC_COUNT - 1);
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 1);

  mode_t            mode_q, mode_d;
  logic [ESC_W-1:0] esc_q, esc_d;
  logic [RST_W-1:0] rcnt_q, rcnt_d;
  logic             cpu_run_q, cpu_rst_q;
  logic             rx_acc;

  always_comb begin
    bios_rx_data  = rx_data;
    cpu_rx_data   = rx_data;
    bios_rx_valid = 1'b0;
    cpu_rx_valid  = 1'b0;
    rx_ready      = 1'b0;
    case (mode_q)
      M_BOOT: begin
        bios_rx_valid = rx_valid;
        rx_ready      = bios_rx_ready;
      end
      M_RUN: begin
        cpu_rx_valid = rx_valid;
        rx_ready     = cpu_rx_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    rx_acc = rx_valid & rx_ready;
    mode_d = mode_q;
    esc_d  = esc_q;
    rcnt_d = rcnt_q;
    case (mode_q)
      M_BOOT: if (boot_req) mode_d = M_RUN;
      M_RUN: begin
        if (rx_acc) begin
          if (rx_data == ESC_CHAR) begin
            if (esc_q == ESC_LAST) mode_d = M_BOOT;
            else                   esc_d  = esc_q + 1'b1;
          end else begin
            esc_d = '0;
          end
        end
      end
      M_CPURST: begin
        if (rcnt_q == '0) mode_d = M_BOOT;
        else              rcnt_d = rcnt_q - 1'b1;
      end
      default: mode_d = M_BOOT;
    endcase
    if (rst_req) begin
      mode_d = M_CPURST;
      rcnt_d = RST_LOAD;
    end
    if (mode_d != mode_q) esc_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= M_BOOT;
      esc_q     <= '0;
      rcnt_q    <= '0;
      cpu_run_q <= 1'b0;
      cpu_rst_q <= 1'b0;
    end else if (clk_en) begin
      mode_q    <= mode_d;
      esc_q     <= esc_d;
      rcnt_q    <= rcnt_d;
      cpu_run_q <= (mode_d == M_RUN);
      cpu_rst_q <= (mode_d == M_CPURST);
    end
  end

  assign mode    = mode_q;
  assign cpu_run = cpu_run_q;
  // Held high while rst is asserted, then follows the registered decode.
  assign cpu_rst = cpu_rst_q | ~rst;

  stream_arb2 #(
    .DATA_W(DATA_W)
  ) u_tx_arb (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .in0_data  (bios_tx_data),
    .in0_valid (bios_tx_valid),
    .in0_en    (1'b1),
    .in0_ready (bios_tx_ready),
    .in1_data  (cpu_tx_data),
    .in1_valid (cpu_tx_valid),
    .in1_en    (mode_q == M_RUN),
    .in1_ready (cpu_tx_ready),
    .out_data  (tx_data),
    .out_valid (tx_valid),
    .out_ready (tx_ready)
  );

endmodule

// File: doc/uart_port_ctrl.md
# uart_port_ctrl

Mode controller and port arbiter between the board UART and its two users: the BIOS command parser and the CPU console GPIO. It owns the BOOT/RUN mode and routes received bytes to exactly one consumer. It merges both transmit streams onto the single UART TX with round-robin arbitration. It also sequences CPU reset on request from the BIOS.

## Interface
Parameters:
- `DATA_W`, default 8: byte width on every stream.
- `ESC_CHAR`, default 8'h1B: escape byte, used in RUN to return to BOOT.
- `ESC_COUNT`, default 3: number of consecutive `ESC_CHAR` bytes that forces BOOT; must be ≥1.
- `RST_CYCLES`, default 16: `cpu_rst` pulse length, counted in enabled cycles; must be ≥1.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `clk_en`, in, 1: global clock enable. All state advances only when it is 1.
- `rx_data` in `DATA_W`, `rx_valid` in 1, `rx_ready` out 1: bytes from the UART receiver.
- `tx_data` out `DATA_W`, `tx_valid` out 1, `tx_ready` in 1: bytes to the UART transmitter.
- `bios_rx_data` out, `bios_rx_valid` out, `bios_rx_ready` in: bytes to the BIOS.
- `bios_tx_data` in, `bios_tx_valid` in, `bios_tx_ready` out: responses from the BIOS.
- `cpu_rx_data` out, `cpu_rx_valid` out, `cpu_rx_ready` in: bytes to the CPU console.
- `cpu_tx_data` in, `cpu_tx_valid` in, `cpu_tx_ready` out: bytes from the CPU console.
- `boot_req` in 1: one-cycle pulse from the BIOS requesting RUN.
- `rst_req` in 1: one-cycle pulse from the BIOS requesting a CPU reset.
- `mode` out 2: current `mode_t` value.
- `cpu_run` out 1: CPU clock enable.
- `cpu_rst` out 1: active-high CPU reset.

## Operation
- Modes: `M_BOOT`, `M_RUN`, `M_CPURST`. Reset enters `M_BOOT`.
- `M_BOOT`:
  - `rx_*` is wired to `bios_rx_*` combinationally.
  - `cpu_rx_valid` is 0 and `cpu_tx_ready` is 0.
  - `boot_req` moves to `M_RUN`.
- `M_RUN`:
  - `rx_*` is wired to `cpu_rx_*`; `bios_rx_valid` is 0.
  - `cpu_run` is 1.
  - The escape counter increments on each accepted byte equal to `ESC_CHAR` and clears on any other accepted byte.
  - When a transfer makes the counter reach `ESC_COUNT`, the block moves to `M_BOOT`. Escape bytes are still forwarded to the CPU.
  - `boot_req` is ignored.
- `M_CPURST`:
  - `cpu_rst` is 1 and `rx_ready` is 0.
  - The counter loads `RST_CYCLES-1` on entry and decrements each enabled cycle. At 0 the block moves to `M_BOOT`.
- `rst_req` moves to `M_CPURST` from any mode.
  - It wins over `boot_req` and over escape completion in the same cycle.
  - `rst_req` arriving in `M_CPURST` reloads the counter.
- The escape counter clears on every mode entry.
- `rx_data` is broadcast to both consumers; only `valid` is gated.
- TX arbitration:
  - One output register (`tx_valid`, `tx_data`).
  - The register may load when it is empty or when `tx_ready` is 1.
  - Candidates: `bios_tx_valid` in all modes; `cpu_tx_valid` only in `M_RUN`.
  - When both request, round-robin: last-granted source loses. After reset the BIOS has priority.
  - The granted source's `*_tx_ready` is 1 in the loading cycle; the other source's ready is 0.
  - A byte already in the register is always delivered, even across mode changes.

## Timing
- All registers update only on `posedge clk` with `clk_en`=1. `rst` low clears them at once, regardless of `clk_en`.
- Reset values: `mode`=`M_BOOT`, `cpu_run`=0, `cpu_rst`=1 while `rst` is low, `tx_valid`=0, `tx_data`=0, escape counter 0, round-robin pointer = BIOS.
- After `rst` release, `cpu_rst` is 0 and the block sits in `M_BOOT`.
- The RX path has zero latency: `rx_ready` follows the selected consumer's ready in the same cycle.
- Mode changes take effect the cycle after the causing event. A byte accepted in the event cycle goes to the old destination.
- TX latency: a source byte accepted in cycle N appears on `tx_*` in cycle N+1.
- Throughput is 1 byte per cycle while `tx_ready`=1.
- `tx_data` stays stable while `tx_valid`=1 and `tx_ready`=0.
- `cpu_run` and `cpu_rst` are registered and decoded from `mode`. `cpu_rst` is high for exactly `RST_CYCLES` enabled cycles.

## Structure
- Shared package:
  - `mode_t` enum: `M_BOOT`=0, `M_RUN`=1, `M_CPURST`=2.
  - `ASCII_ESC` constant, the default for `ESC_CHAR`.
- One sub-module, `stream_arb2`: a 2:1 round-robin arbiter with an output register and per-input enable. It is instantiated once for TX.
- Mode FSM, reset counter, escape counter and RX steering stay in `uart_port_ctrl`.

## Test plan
- Release reset, then send rx 'n','o','p' with `bios_rx_ready`=1: all three appear on `bios_rx`; `cpu_rx_valid` stays 0; `mode`=0, `cpu_run`=0.
- Pulse `boot_req`, then send 'A': `mode`=1 the next cycle, 'A' reaches `cpu_rx`, `cpu_run`=1.
- In RUN, send ESC, 'x', ESC, ESC, ESC: all five bytes are forwarded; `mode` returns to 0 the cycle after the third consecutive ESC.
- In RUN, hold `bios_tx_valid` and `cpu_tx_valid` with `tx_ready`=1: `tx_data` alternates BIOS, CPU, BIOS, ….
  - Drop `tx_ready` for 3 cycles: data holds, and both source readies are 0.
- In RUN, pulse `rst_req` and `boot_req` in the same cycle: `mode`=2 and `cpu_rst`=1 for exactly 16 enabled cycles, then `mode`=0.
  - With `clk_en` toggling every other cycle, the pulse spans 32 clocks.
- Assert `rst` low mid-transfer (`tx_valid`=1, `mode`=1): outputs reach their reset values immediately, without waiting for a clock edge.
